// File: rtl/x_mux_trigger_multi.sv
// x_mux_trigger_multi: multi-channel delay-line trigger capture with arm/timeout FSM and valid/ready readout.
// Define X_MUX_TRIGGER_BUBBLE_EN to majority-filter interior taps before thermometer decode.
module x_mux_trigger_multi #(
  parameter int WIDTH = 32,
  parameter int CHANNELS = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 255,
  localparam int POS_W = $clog2(WIDTH + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_nrst,
  input  logic                      i_arm,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic                      i_ready,
  output logic [CHANNELS*WIDTH-1:0] o_data,
  output logic [CHANNELS*POS_W-1:0] o_pos,
  output logic [CHANNELS-1:0]       o_hit,
  output logic                      o_timeout,
  output logic                      o_valid,
  output logic                      o_busy
);
  localparam int DW = CHANNELS * WIDTH;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, ARMED, HOLD} state_t;

  state_t                    state, state_nx;
  logic [SYNC_STAGES*DW-1:0] sync_q;
  logic [DW-1:0]             s;
  logic [CW-1:0]             cnt;
  logic [CHANNELS*POS_W-1:0] pos;
  logic [CHANNELS-1:0]       hit;
  logic                      cnt_done;
  logic                      cap;

  function automatic logic [POS_W-1:0] thermo(input logic [WIDTH-1:0] v);
    logic [POS_W-1:0] p;
    logic             run;
    p = '0;
    run = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      run = run & v[i];
      p = p + POS_W'(run);
    end
    return p;
  endfunction

  // stage 0 sits in the low bits; the oldest stage (S) is the top slice
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) sync_q <= '0;
    else sync_q <= (SYNC_STAGES*DW)'({sync_q, i_data});

  assign s = sync_q[SYNC_STAGES*DW-1 -: DW];

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] raw, f;
    logic [POS_W-1:0] p;
    assign raw = s[c*WIDTH +: WIDTH];
`ifdef X_MUX_TRIGGER_BUBBLE_EN
    always_comb begin
      f = raw;
      for (int i = 1; i < WIDTH - 1; i++)
        f[i] = (raw[i-1] & raw[i]) | (raw[i] & raw[i+1]) | (raw[i-1] & raw[i+1]);
    end
`else
    assign f = raw;
`endif
    assign p = thermo(f);
    assign pos[c*POS_W +: POS_W] = p;
    assign hit[c] = (p != '0) && (p != POS_W'(WIDTH));
  end

  assign cnt_done = cnt == CW'(TIMEOUT - 1);

  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = i_arm ? ARMED : IDLE;
      ARMED:   state_nx = (|hit || cnt_done) ? HOLD : ARMED;
      HOLD:    state_nx = i_ready ? IDLE : HOLD;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    o_valid = state == HOLD;
    o_busy = state != IDLE;
    cap = (state == ARMED) && (|hit || cnt_done);
  end

  // an edge on any channel outranks a simultaneous timeout
  always_ff @(posedge i_clk or negedge i_nrst)
    if (!i_nrst) begin
      cnt <= '0;
      o_data <= '0;
      o_pos <= '0;
      o_hit <= '0;
      o_timeout <= 1'b0;
    end else begin
      cnt <= state == ARMED ? cnt + 1'b1 : '0;
      if (cap) begin
        o_data <= s;
        o_pos <= pos;
        o_hit <= hit;
        o_timeout <= ~|hit;
      end
    end
endmodule

// File: tb/tb_x_mux_trigger_multi.sv
// tb_x_mux_trigger_multi: scoreboard bench with a trace-based reference model for x_mux_trigger_multi.
module tb_x_mux_trigger_multi;
  localparam int WIDTH = 32;
  localparam int CHANNELS = 2;
  localparam int SS = 2;
  localparam int TIMEOUT = 16;
  localparam int POS_W = $clog2(WIDTH + 1);
  localparam int DW = CHANNELS * WIDTH;

  logic                      i_clk = 1'b0;
  logic                      i_nrst = 1'b0;
  logic                      i_arm = 1'b0;
  logic                      i_ready = 1'b0;
  logic [DW-1:0]             i_data = '0;
  logic [DW-1:0]             o_data;
  logic [CHANNELS*POS_W-1:0] o_pos;
  logic [CHANNELS-1:0]       o_hit;
  logic                      o_timeout, o_valid, o_busy;

  x_mux_trigger_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SYNC_STAGES(SS), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_arm(i_arm), .i_data(i_data), .i_ready(i_ready),
    .o_data(o_data), .o_pos(o_pos), .o_hit(o_hit), .o_timeout(o_timeout),
    .o_valid(o_valid), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0]             d;
    logic [CHANNELS*POS_W-1:0] p;
    logic [CHANNELS-1:0]       h;
    logic                      t;
    int                        e;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] hist[$];
  logic [DW-1:0] plan[$];
  int            checks = 0;
  int            errors = 0;
  bit            bp = 1'b0;

  // hist[e] is what the DUT's first sync stage took at edge e (zero while in reset)
  always @(posedge i_clk) hist.push_back(i_nrst ? i_data : '0);

  initial forever begin
    @(negedge i_clk);
    i_ready = bp ? 1'b0 : ($urandom % 4 != 0);
  end

  task automatic chk(input string n, input logic [DW-1:0] a, input logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  function automatic int tpos(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] f;
    logic [WIDTH:0]   x;
    f = v;
`ifdef X_MUX_TRIGGER_BUBBLE_EN
    for (int i = 1; i < WIDTH - 1; i++) f[i] = (int'(v[i-1]) + int'(v[i]) + int'(v[i+1])) >= 2;
`endif
    x = {1'b0, f};
    return $countones(x ^ (x + 1'b1)) - 1;
  endfunction

  function automatic logic [DW-1:0] dat(input int e, input int a);
    if (e < 0) return '0;
    if (e < a) return hist[e];
    return plan[e - a];
  endfunction

  task automatic predict(input int a);
    exp_t          x;
    logic [DW-1:0] v;
    int            p;
    for (int k = 1; k <= TIMEOUT; k++) begin
      v = dat(a + k - SS, a);
      x.h = '0;
      for (int c = 0; c < CHANNELS; c++) begin
        p = tpos(v[c*WIDTH +: WIDTH]);
        x.p[c*POS_W +: POS_W] = POS_W'(p);
        x.h[c] = (p >= 1) && (p <= WIDTH - 1);
      end
      if (|x.h || k == TIMEOUT) begin
        x.d = v;
        x.t = ~|x.h;
        x.e = a + k;
        exp_q.push_back(x);
        return;
      end
    end
  endtask

  function automatic logic [WIDTH-1:0] rnd_word(input bit quiet);
    logic [WIDTH-1:0] w;
    int               p;
    if (quiet) return ($urandom % 2) ? {WIDTH{1'b1}} : '0;
    case ($urandom % 5)
      0: begin p = $urandom_range(1, WIDTH - 1); w = (WIDTH'(1) << p) - 1'b1; end
      1: begin
        p = $urandom_range(4, WIDTH - 1);
        w = (WIDTH'(1) << p) - 1'b1;
        w[$urandom_range(1, p - 3)] = 1'b0;
      end
      2: w = WIDTH'($urandom);
      3: w = {WIDTH{1'b1}};
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [DW-1:0] rnd_data(input bit quiet);
    logic [DW-1:0] d;
    for (int c = 0; c < CHANNELS; c++) d[c*WIDTH +: WIDTH] = rnd_word(quiet);
    return d;
  endfunction

  task automatic run();
    int a;
    a = hist.size();
    predict(a);
    i_arm = 1'b1;
    i_data = plan[0];
    for (int i = 1; i < plan.size(); i++) begin
      @(negedge i_clk);
      if (i == 1) chk("busy_armed", DW'(o_busy), DW'(1));
      i_arm = 1'b0;
      i_data = plan[i];
    end
  endtask

  task automatic drain();
    for (int n = 0; n <= 300; n++) begin
      @(negedge i_clk);
      i_arm = 1'b0;
      i_data = rnd_data(1'b0);
      if (exp_q.size() == 0) begin
        chk("busy_idle", DW'(o_busy), DW'(0));
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL drain_timeout: got %0d pending captures expected 0", exp_q.size());
    exp_q.delete();
    i_nrst = 1'b0;
    repeat (2) @(negedge i_clk);
    i_nrst = 1'b1;
  endtask

  task automatic directed(input logic [DW-1:0] pre, input logic [DW-1:0] val, input int lead);
    repeat (3) begin
      @(negedge i_clk);
      i_data = pre;
    end
    @(negedge i_clk);
    plan.delete();
    for (int i = 0; i <= TIMEOUT; i++) plan.push_back(i < lead ? pre : val);
    run();
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 40; n++) begin
      @(negedge i_clk);
      i_arm = 1'b0;
      if (o_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_valid: got o_valid 0 expected 1");
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_data"}, o_data, '0);
    chk({n, "_pos"}, DW'(o_pos), '0);
    chk({n, "_hit"}, DW'(o_hit), '0);
    chk({n, "_timeout"}, DW'(o_timeout), '0);
    chk({n, "_valid"}, DW'(o_valid), '0);
    chk({n, "_busy"}, DW'(o_busy), '0);
  endtask

  initial begin : mon
    bit                        pv = 1'b0;
    bit                        acc = 1'b0;
    int                        re = 0;
    exp_t                      x;
    logic [DW-1:0]             sd;
    logic [CHANNELS*POS_W-1:0] sp;
    logic [CHANNELS-1:0]       sh;
    logic                      st;
    forever begin
      @(negedge i_clk);
      #1;
      if (!i_nrst) begin
        pv = 1'b0;
        acc = 1'b0;
        continue;
      end
      if (acc) chk("valid_drop", DW'(o_valid), DW'(0));
      if (pv) begin
        chk("valid_hold", DW'(o_valid), DW'(1));
        chk("hold_data", o_data, sd);
        chk("hold_pos", DW'(o_pos), DW'(sp));
        chk("hold_hit", DW'(o_hit), DW'(sh));
        chk("hold_timeout", DW'(o_timeout), DW'(st));
      end else if (o_valid) begin
        re = hist.size() - 1;
        sd = o_data;
        sp = o_pos;
        sh = o_hit;
        st = o_timeout;
      end
      acc = o_valid && i_ready;
      if (acc) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_capture: got capture at edge %0d expected none", re);
        end else begin
          x = exp_q.pop_front();
          chk("cap_data", o_data, x.d);
          chk("cap_pos", DW'(o_pos), DW'(x.p));
          chk("cap_hit", DW'(o_hit), DW'(x.h));
          chk("cap_timeout", DW'(o_timeout), DW'(x.t));
          chk("cap_edge", DW'(re), DW'(x.e));
        end
      end
      pv = o_valid && !i_ready;
    end
  end

  initial begin
    i_data = '1;
    repeat (3) @(negedge i_clk);
    chk_zero("reset");
    i_nrst = 1'b1;
    i_data = '0;
    @(negedge i_clk);
    chk("post_reset_busy", DW'(o_busy), DW'(0));

    directed('0, {32'h0000_0000, 32'h0000_00FF}, 1);
    drain();
    directed('0, {32'h0000_0003, 32'h0000_FFFF}, 1);
    drain();
    directed('0, {32'h0000_0000, 32'hFFFF_FFFF}, 0);
    drain();
    directed('0, '0, 0);
    drain();
    directed('0, {32'h0000_0000, 32'h0000_00F7}, 1);
    drain();

    for (int t = 0; t < 40; t++) begin
      bit q;
      q = ($urandom % 3 == 0);
      plan.delete();
      for (int i = 0; i <= TIMEOUT; i++) plan.push_back(rnd_data(q || ($urandom % 4 != 0)));
      run();
      drain();
    end

    bp = 1'b1;
    directed('0, {32'h0000_0000, 32'h0000_00FF}, 1);
    wait_valid();
    repeat (5) begin
      @(negedge i_clk);
      i_arm = ~i_arm;
      i_data = rnd_data(1'b0);
    end
    i_arm = 1'b0;
    bp = 1'b0;
    drain();

    bp = 1'b1;
    directed('0, {32'h0000_0003, 32'h0000_FFFF}, 1);
    wait_valid();
    @(negedge i_clk);
    #3 i_nrst = 1'b0;
    #1 chk_zero("async_reset");
    exp_q.delete();
    repeat (2) @(negedge i_clk);
    i_nrst = 1'b1;
    bp = 1'b0;
    @(negedge i_clk);
    chk("rerelease_busy", DW'(o_busy), DW'(0));
    directed('0, '0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
